nios2_oci_ram_arbiter: RTL and testbench



---
 rtl/nios2_oci_ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_nios2_oci_ram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_ram_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG monitor commands and the CPU Avalon debug slave.
// Optional `OCI_ARB_ROUND_ROBIN_EN: alternate contested grants; otherwise JTAG has fixed priority.
module nios2_oci_ram_arbiter #(
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned RAM_DW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [RAM_AW-1:0] cpu_address,
  input  logic [RAM_DW-1:0] cpu_writedata,
  output logic [RAM_DW-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [RAM_DW-1:0] ram_rdata,
  output logic [RAM_AW-1:0] MonAReg,
  output logic [RAM_DW-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  logic [0:0] state, state_nxt;
  logic       jtag_pend, jtag_wr, rd_jtag;
  logic       cpu_req, jtag_first, grant_jtag, grant_cpu, jtag_done;
  logic       accept_a, accept_b, collide;
  logic       unused_jdo;

  assign unused_jdo   = ^{jdo[37:35], jdo[2:0]};
  assign cpu_req      = cpu_read | cpu_write;
  assign cpu_readdata = ram_rdata;

  // jtag_pend stays set until completion, so it also covers an access in flight.
  assign collide  = (take_action_ocimem_a | take_action_ocimem_b) & jtag_pend;
  assign accept_a = take_action_ocimem_a & ~jtag_pend;
  assign accept_b = take_action_ocimem_b & ~take_action_ocimem_a & ~jtag_pend;

`ifdef OCI_ARB_ROUND_ROBIN_EN
  logic last_cpu;

  assign jtag_first = ~cpu_req | last_cpu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cpu <= 1'b1;
    end else if (state == IDLE && jtag_pend && cpu_req) begin
      last_cpu <= ~last_cpu;
    end
  end
`else
  assign jtag_first = 1'b1;
`endif

  // Strobes are gated by reset_n so nothing reaches the RAM while reset is held.
  always_comb begin
    state_nxt       = state;
    grant_jtag      = 1'b0;
    grant_cpu       = 1'b0;
    jtag_done       = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    cpu_waitrequest = cpu_req;
    case (state)
      IDLE: begin
        if (reset_n) begin
          if (jtag_pend && jtag_first) grant_jtag = 1'b1;
          else if (cpu_req)            grant_cpu  = 1'b1;
        end
        if (grant_jtag) begin
          ram_addr = MonAReg;
          if (jtag_wr) begin
            ram_we    = 1'b1;
            ram_wdata = MonDReg;
            jtag_done = 1'b1;
          end else begin
            ram_re    = 1'b1;
            state_nxt = RD_WAIT;
          end
        end else if (grant_cpu) begin
          ram_addr = cpu_address;
          if (cpu_write) begin
            ram_we          = 1'b1;
            ram_wdata       = cpu_writedata;
            cpu_waitrequest = 1'b0;
          end else begin
            ram_re    = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        state_nxt = IDLE;
        if (rd_jtag) jtag_done = 1'b1;
        else         cpu_waitrequest = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      jtag_pend     <= 1'b0;
      jtag_wr       <= 1'b0;
      rd_jtag       <= 1'b0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) rd_jtag <= grant_jtag;

      if (accept_a) begin
        MonAReg       <= RAM_AW'(jdo[25:18]);
        jtag_pend     <= jdo[17];
        jtag_wr       <= 1'b0;
        monitor_error <= 1'b0;
      end else if (accept_b) begin
        MonDReg   <= RAM_DW'(jdo[34:3]);
        jtag_pend <= 1'b1;
        jtag_wr   <= 1'b1;
      end else if (jtag_done) begin
        jtag_pend <= 1'b0;
        MonAReg   <= MonAReg + RAM_AW'(1);
      end

      if (state == RD_WAIT && rd_jtag) MonDReg <= ram_rdata;
      if (collide) monitor_error <= 1'b1;
      monitor_ready <= ~(jtag_pend | accept_a | accept_b);
    end
  end

endmodule

// File: tb/tb_nios2_oci_ram_arbiter.sv
// Directed and randomized checks of nios2_oci_ram_arbiter against a memory-array reference.
module tb_nios2_oci_ram_arbiter;

`ifdef OCI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_a = 1'b0, take_b = 1'b0;
  logic [37:0] jdo = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic [7:0]  mon_a;
  logic [31:0] mon_d;
  logic        monitor_ready, monitor_error;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        mem_init = 1'b1;
  int          we_count = 0;
  int          total = 0, bad = 0;
  logic [7:0]  exp_a;
  logic [31:0] exp_d;

  always #5 clk = ~clk;

  nios2_oci_ram_arbiter #(.RAM_AW(8), .RAM_DW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b), .jdo(jdo),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata),
    .MonAReg(mon_a), .MonDReg(mon_d),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  function automatic logic [31:0] init_val(input int unsigned i);
    return ((i + 1) * 32'h9E3779B9) ^ i;
  endfunction

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (ram_we) we_count <= we_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic do_reset;
    int wc;
    wc = we_count;
    reset_n   = 1'b0;
    cpu_write = 1'b1;
    cpu_address = 8'h05;
    cpu_writedata = 32'h0BADF00D;
    repeat (3) begin
      step; neg;
      chk("rst_we", ram_we, 0);
      chk("rst_re", ram_re, 0);
      chk("rst_waitreq", cpu_waitrequest, 1);
      chk("rst_areg", mon_a, 0);
      chk("rst_dreg", mon_d, 0);
      chk("rst_ready", monitor_ready, 1);
      chk("rst_error", monitor_error, 0);
    end
    chk("rst_no_strobe", we_count, wc);
    cpu_write = 1'b0;
    mem_init  = 1'b0;
    step;
    reset_n = 1'b1;
    neg;
    chk("rst_waitreq_idle", cpu_waitrequest, 0);
    exp_a = 8'h00;
    exp_d = 32'h0;
  endtask

  task automatic jtag_set(input logic [7:0] addr, input logic rd);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[25:18] = addr;
    j[17] = rd;
    step; take_a = 1'b1; jdo = j;
    step; take_a = 1'b0;
    exp_a = addr;
    if (rd) begin
      neg;
      chk("jr_re", ram_re, 1);
      chk("jr_addr", ram_addr, addr);
      chk("jr_rdy_n0", monitor_ready, 0);
      step; neg;
      chk("jr_rdy_n1", monitor_ready, 0);
      step; neg;
      exp_d = ref_mem[addr];
      exp_a = addr + 8'd1;
      chk("jr_dreg", mon_d, exp_d);
      chk("jr_areg", mon_a, exp_a);
      chk("jr_rdy_n2", monitor_ready, 0);
      step; neg;
      chk("jr_rdy_n3", monitor_ready, 1);
    end else begin
      neg;
      chk("ja_areg", mon_a, addr);
      chk("ja_no_re", ram_re, 0);
      chk("ja_no_we", ram_we, 0);
      step; neg;
      chk("ja_rdy", monitor_ready, 1);
    end
    chk("ja_err_clear", monitor_error, 0);
  endtask

  task automatic jtag_write(input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[34:3] = d;
    step; take_b = 1'b1; jdo = j;
    step; take_b = 1'b0;
    neg;
    chk("jw_we", ram_we, 1);
    chk("jw_addr", ram_addr, exp_a);
    chk("jw_wdata", ram_wdata, d);
    chk("jw_rdy_n0", monitor_ready, 0);
    ref_mem[exp_a] = d;
    exp_a = exp_a + 8'd1;
    exp_d = d;
    step; neg;
    chk("jw_areg", mon_a, exp_a);
    chk("jw_dreg", mon_d, exp_d);
    chk("jw_rdy_n1", monitor_ready, 0);
    step; neg;
    chk("jw_rdy_n2", monitor_ready, 1);
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    step; cpu_write = 1'b1; cpu_address = a; cpu_writedata = d;
    neg;
    chk("cw_waitreq", cpu_waitrequest, 0);
    chk("cw_we", ram_we, 1);
    chk("cw_addr", ram_addr, a);
    chk("cw_wdata", ram_wdata, d);
    ref_mem[a] = d;
    step; cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output int waits, output logic [31:0] data);
    bit ok;
    ok = 1'b0;
    waits = 0;
    data = 'x;
    step; cpu_read = 1'b1; cpu_address = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      neg;
      if (cpu_waitrequest === 1'b0) begin
        ok = 1'b1;
        data = cpu_readdata;
      end else begin
        waits++;
        step;
      end
    end
    step; cpu_read = 1'b0;
    chk("cr_completed", ok, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          waits;
    logic [31:0] rdat, d;
    logic [37:0] j;
    int          wc;
    bit          ok, rdy;
    int          exp_waits;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    do_reset();

    // JTAG write then read-back with auto-increment
    jtag_set(8'h10, 1'b0);
    jtag_write(32'hDEADBEEF);
    chk("tp_areg_11", mon_a, 8'h11);
    jtag_set(8'h10, 1'b1);
    chk("tp_dreg_deadbeef", mon_d, 32'hDEADBEEF);
    chk("tp_areg_11b", mon_a, 8'h11);

    // CPU write and read
    cpu_wr(8'h20, 32'h12345678);
    cpu_rd(8'h20, waits, rdat);
    chk("tp_cpu_rd_waits", waits, 1);
    chk("tp_cpu_rd_data", rdat, 32'h12345678);

    // Address wrap
    jtag_set(8'hFF, 1'b0);
    jtag_write(32'hA5A55A5A);
    chk("wrap_areg", mon_a, 8'h00);
    cpu_rd(8'hFF, waits, rdat);
    chk("wrap_ram", rdat, 32'hA5A55A5A);

    // Collision: second pulse lands while the JTAG read is in RD_WAIT
    j = '0; j[25:18] = 8'h50; j[17] = 1'b1;
    step; take_a = 1'b1; jdo = j;
    step; take_a = 1'b0;
    step;
    j = '0; j[34:3] = 32'hBAD0BAD0;
    take_b = 1'b1; jdo = j;
    wc = we_count;
    step; take_b = 1'b0;
    neg;
    chk("coll_error", monitor_error, 1);
    chk("coll_dreg", mon_d, ref_mem[8'h50]);
    chk("coll_areg", mon_a, 8'h51);
    step; step; neg;
    chk("coll_ready", monitor_ready, 1);
    chk("coll_no_write", we_count, wc);
    chk("coll_error_sticky", monitor_error, 1);
    exp_a = 8'h51;
    cpu_rd(8'h51, waits, rdat);
    chk("coll_ram_untouched", rdat, ref_mem[8'h51]);
    jtag_set(8'h30, 1'b0);

    // Randomized sequential traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] ra;
      ra = 8'($urandom());
      d  = $urandom();
      case ($urandom_range(0, 4))
        0: cpu_wr(ra, d);
        1: begin
          cpu_rd(ra, waits, rdat);
          chk("rnd_cpu_waits", waits, 1);
          chk("rnd_cpu_data", rdat, ref_mem[ra]);
        end
        2: jtag_set(ra, 1'b0);
        3: jtag_write(d);
        default: jtag_set(ra, 1'b1);
      endcase
    end

    // Contention: CPU read raised while a JTAG write is already pending
    do_reset();
    jtag_set(8'h40, 1'b0);
    for (int k = 0; k < 4; k++) begin
      d = $urandom();
      j = 38'({$urandom(), $urandom()});
      j[34:3] = d;
      step; take_b = 1'b1; jdo = j;
      step; take_b = 1'b0; cpu_read = 1'b1; cpu_address = 8'h80 + 8'(k);
      ok = 1'b0; waits = 0; rdat = 'x;
      for (int i = 0; i < 20 && !ok; i++) begin
        neg;
        if (cpu_waitrequest === 1'b0) begin
          ok = 1'b1;
          rdat = cpu_readdata;
        end else begin
          waits++;
          step;
        end
      end
      step; cpu_read = 1'b0;
      exp_waits = (RR && (k % 2 == 1)) ? 1 : 2;
      chk("ct_done", ok, 1);
      chk("ct_waits", waits, exp_waits);
      chk("ct_data", rdat, ref_mem[8'h80 + 8'(k)]);
      ref_mem[exp_a] = d;
      exp_a = exp_a + 8'd1;
      rdy = 1'b0;
      for (int i = 0; i < 10 && !rdy; i++) begin
        neg;
        if (monitor_ready === 1'b1) rdy = 1'b1;
        else step;
      end
      chk("ct_ready", rdy, 1);
      chk("ct_areg", mon_a, exp_a);
      chk("ct_dreg", mon_d, d);
    end
    for (int k = 0; k < 4; k++) begin
      cpu_rd(8'h40 + 8'(k), waits, rdat);
      chk("ct_ram", rdat, ref_mem[8'h40 + 8'(k)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
